// File: rtl/z80_bus_master.sv
// z80_bus_master
//   Transaction-driven Z80 bus initiator. Each accepted command becomes one
//   Z80-style machine cycle (opcode fetch with refresh, memory read/write,
//   I/O read/write) on the classic strobes. Read data and the completion
//   status come back through a one-cycle response strobe.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_op                0=M1 fetch 1=MEMRD 2=MEMWR 3=IORD 4=IOWR (5..7 illegal)
//   cmd_addr, cmd_wdata   cycle address and write data
//   rsp_valid/data/err    completion pulse, captured read data, error flag
//   A, dout, di           address bus, write data bus, read data bus
//   wait_n                responder wait request
//   m1_n .. rfsh_n        active-low bus strobes
module z80_bus_master #(
  parameter int IO_WAIT  = 1,   // automatic I/O wait states (0..3)
  parameter int WAIT_MAX = 255  // external TW cycles tolerated before abort (1..255)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic [15:0] A,
  output logic [7:0]  dout,
  input  logic [7:0]  di,
  input  logic        wait_n,
  output logic        m1_n,
  output logic        mreq_n,
  output logic        iorq_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        rfsh_n
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TWI, S_TW, S_T3, S_T4} state_t;
  typedef enum logic [2:0] {OP_M1, OP_MEMRD, OP_MEMWR, OP_IORD, OP_IOWR} op_t;

  localparam logic [1:0] IO_WAIT_L  = 2'(IO_WAIT);
  localparam logic [7:0] WAIT_MAX_L = 8'(WAIT_MAX);
  localparam bit         HAS_TWI    = (IO_WAIT != 0);

  state_t      state, state_next;
  op_t         op_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [1:0]  twi_cnt;   // 1-based index of the current TWI cycle
  logic [7:0]  tw_cnt;    // 1-based index of the current TW cycle
  logic [6:0]  r_cnt;     // refresh counter R[6:0]
  logic [15:0] a_last;    // A holds its last value while the bus is idle
  logic [7:0]  dout_last;

  logic accept, op_legal, is_io, tw_timeout, fetch_capture, read_capture;

  assign op_legal   = (cmd_op <= 3'd4);
  assign cmd_ready  = (state == S_IDLE) && !rsp_valid;
  assign accept     = cmd_valid && cmd_ready;
  assign is_io      = (op_q == OP_IORD) || (op_q == OP_IOWR);
  assign tw_timeout = (state == S_TW) && !wait_n && (tw_cnt == WAIT_MAX_L);

  // Fetch data is taken as the cycle leaves T2/TW; other reads at the end of T3.
  assign fetch_capture = (op_q == OP_M1) && (state_next == S_T3) &&
                         ((state == S_T2) || (state == S_TW));
  assign read_capture  = (state == S_T3) && ((op_q == OP_MEMRD) || (op_q == OP_IORD));

  // State register
  // NOTE: clocked state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept && op_legal) state_next = S_T1;
      S_T1:   state_next = S_T2;
      S_T2: begin
        if (is_io && HAS_TWI) state_next = S_TWI;
        else                  state_next = wait_n ? S_T3 : S_TW;
      end
      S_TWI: if (twi_cnt == IO_WAIT_L) state_next = wait_n ? S_T3 : S_TW;
      S_TW: begin
        if (wait_n)          state_next = S_T3;
        else if (tw_timeout) state_next = S_IDLE;
      end
      S_T3:    state_next = (op_q == OP_M1) ? S_T4 : S_IDLE;
      S_T4:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Command, counters and response
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q      <= OP_M1;
      addr_q    <= '0;
      wdata_q   <= '0;
      twi_cnt   <= 2'd1;
      tw_cnt    <= 8'd1;
      r_cnt     <= '0;
      a_last    <= '0;
      dout_last <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      a_last    <= A;
      dout_last <= dout;
      twi_cnt   <= (state == S_TWI) ? twi_cnt + 2'd1 : 2'd1;
      tw_cnt    <= (state == S_TW)  ? tw_cnt + 8'd1  : 8'd1;

      if (accept) begin
        if (op_legal) begin
          op_q    <= op_t'(cmd_op);
          addr_q  <= cmd_addr;
          wdata_q <= cmd_wdata;
        end else begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
        end
      end

      if (tw_timeout) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
      end
      if ((state == S_T3) && (op_q != OP_M1)) rsp_valid <= 1'b1;
      if (state == S_T4) begin
        rsp_valid <= 1'b1;
        r_cnt     <= r_cnt + 7'd1;
      end
      if (fetch_capture || read_capture) rsp_data <= di;
    end
  end

  // Bus outputs decoded from state and the registered command
  always_comb begin
    m1_n   = 1'b1;
    mreq_n = 1'b1;
    iorq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    rfsh_n = 1'b1;
    A      = a_last;
    dout   = dout_last;
    case (state)
      S_T1, S_T2, S_TWI, S_TW, S_T3: begin
        if ((state == S_T3) && (op_q == OP_M1)) begin
          mreq_n = 1'b0;
          rfsh_n = 1'b0;
          A      = {8'h00, 1'b0, r_cnt};
        end else begin
          A = addr_q;
          case (op_q)
            OP_M1: begin
              m1_n   = 1'b0;
              mreq_n = 1'b0;
              rd_n   = 1'b0;
            end
            OP_MEMRD: begin
              mreq_n = 1'b0;
              rd_n   = 1'b0;
            end
            OP_MEMWR: begin
              mreq_n = 1'b0;
              dout   = wdata_q;
              wr_n   = (state == S_T1);
            end
            OP_IORD: begin
              iorq_n = (state == S_T1);
              rd_n   = (state == S_T1);
            end
            OP_IOWR: begin
              dout   = wdata_q;
              iorq_n = (state == S_T1);
              wr_n   = (state == S_T1);
            end
            default: ;
          endcase
        end
      end
      S_T4: begin
        rfsh_n = 1'b0;
        A      = {8'h00, 1'b0, r_cnt};
      end
      default: ;
    endcase
  end

endmodule
